multicycle_ctrl: RTL

//   Multicycle control FSM for the 16-bit, 3-bit-opcode MIPS-style CPU.
//   - Sequences one shared ALU, one shared memory port and the register file

---
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit MIPS-style CPU: sequences the shared ALU,
// memory port and register file, with a memory-wait watchdog that halts on timeout.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       link,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state
);

  localparam logic [2:0] OP_RTYPE = 3'b000, OP_LW = 3'b001, OP_SW = 3'b010, OP_ADDI = 3'b011,
                         OP_SUBI  = 3'b100, OP_BEQ = 3'b101, OP_J = 3'b110, OP_JAL = 3'b111;
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  // ADDI and SUBI get separate execute states so op is never consulted after MEMADR.
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_ADDIEX, S_SUBIEX, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_HALT
  } state_t;

  state_t     cur_state, nxt_state;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       req_entry;

  assign state   = cur_state;
  assign mem_req = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
  // A mem_ready on the cycle the count would reach MAX_WAIT still completes normally.
  assign timeout = mem_req && !mem_ready && (wait_cnt == WAIT_LIMIT);
  assign req_entry = (nxt_state != cur_state) &&
                     ((nxt_state == S_FETCH) || (nxt_state == S_MEMRD) || (nxt_state == S_MEMWR));

  // NOTE: every output and nxt_state gets a default before the case so no path can infer a latch.
  always_comb begin
    nxt_state  = cur_state;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    link       = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    unique case (cur_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite   = 1'b1;
          pcen      = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXEC;
          OP_ADDI:      nxt_state = S_ADDIEX;
          OP_SUBI:      nxt_state = S_SUBIEX;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
          OP_JAL:       nxt_state = S_JAL;
          default:      nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        nxt_state = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_ADDIEX, S_SUBIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        aluop     = (cur_state == S_SUBIEX) ? 2'b01 : 2'b00;
        nxt_state = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        pcen       = zero;
        instr_done = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_JUMP, S_JAL: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        regwrite   = (cur_state == S_JAL);
        link       = (cur_state == S_JAL);
        instr_done = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_HALT: fault = 1'b1;
      default: nxt_state = S_FETCH;
    endcase
    if (timeout) nxt_state = S_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      if (req_entry || mem_ready)           wait_cnt <= 8'd0;
      else if (mem_req && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule
